// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: sequencer states, forwarding selects, x0 index.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_e;

    localparam int unsigned REG_X0 = 0;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-side bundle: hazard sources from D/E/M/W and the stage stall/flush/forward controls.
interface pipe_hazard_ctrl_if #(
    parameter int REG_ADDR_W = 5
);
    logic [REG_ADDR_W-1:0] rs1_D, rs2_D, rs1_E, rs2_E;
    logic [REG_ADDR_W-1:0] rd_E, rd_M, rd_W;
    logic                  use_rs1_D, use_rs2_D;
    logic                  load_E, regwe_M, regwe_W;
    logic                  redirect_E, mem_req_M, mem_ack_M;
    logic                  stall_F, stall_D, stall_E, stall_M;
    logic                  flush_D, flush_E;
    logic [1:0]            fwd_a_E, fwd_b_E;

    modport master (
        output rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W,
        output use_rs1_D, use_rs2_D, load_E, regwe_M, regwe_W,
        output redirect_E, mem_req_M, mem_ack_M,
        input  stall_F, stall_D, stall_E, stall_M, flush_D, flush_E,
        input  fwd_a_E, fwd_b_E
    );

    modport slave (
        input  rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W,
        input  use_rs1_D, use_rs2_D, load_E, regwe_M, regwe_W,
        input  redirect_E, mem_req_M, mem_ack_M,
        output stall_F, stall_D, stall_E, stall_M, flush_D, flush_E,
        output fwd_a_E, fwd_b_E
    );
endinterface

// File: rtl/pipe_hazard_ctrl_fwd.sv
// Per-operand Execute forwarding select; purely combinational, Memory result wins over Writeback.
module fwd_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] rs_E,
    input  logic [REG_ADDR_W-1:0] rd_M,
    input  logic [REG_ADDR_W-1:0] rd_W,
    input  logic                  regwe_M,
    input  logic                  regwe_W,
    output logic [1:0]            sel
);
    localparam logic [REG_ADDR_W-1:0] X0 = REG_ADDR_W'(REG_X0);

    always_comb begin
        sel = FWD_RF;
        if (regwe_M && rd_M != X0 && rd_M == rs_E) begin
            sel = FWD_M;
        end else if (regwe_W && rd_W != X0 && rd_W == rs_E) begin
            sel = FWD_W;
        end
    end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// 5-stage pipeline sequencer: Mealy stall/flush/forward controls, memory-wait timeout, sticky error.
// Optional saturating stall/flush counters built only when PIPE_HAZARD_PERF_EN is defined.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W  = 5,
    parameter int MEM_TIMEOUT = 16,
    parameter int PERF_CNT_W  = 32
) (
    input  logic                  clk,
    input  logic                  rstn,
    pipe_hazard_ctrl_if.slave     hz,
    output logic                  mem_err,
    output logic [PERF_CNT_W-1:0] perf_stall_cnt,
    output logic [PERF_CNT_W-1:0] perf_flush_cnt
);
    localparam int CNT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(MEM_TIMEOUT - 2);
    localparam logic [REG_ADDR_W-1:0] X0       = REG_ADDR_W'(REG_X0);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             lu, run_rules, stall_all, stall_fd, flush_d, flush_e;
    logic [1:0]       fwd_a, fwd_b;

    assign lu = hz.load_E && hz.rd_E != X0 &&
                ((hz.use_rs1_D && hz.rs1_D == hz.rd_E) ||
                 (hz.use_rs2_D && hz.rs2_D == hz.rd_E));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        run_rules = 1'b0;
        stall_all = 1'b0;
        stall_fd  = 1'b0;
        flush_d   = 1'b0;
        flush_e   = 1'b0;
        case (state_q)
            RUN: run_rules = 1'b1;
            MEM_WAIT: begin
                if (!hz.mem_ack_M) begin
                    stall_all = 1'b1;
                    cnt_d     = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) state_d = ERROR;
                end else begin
                    state_d   = RUN;
                    run_rules = 1'b1;
                end
            end
            ERROR:   stall_all = 1'b1;
            default: state_d   = RUN;
        endcase
        // The ack cycle of a wait falls through to the normal RUN priority chain.
        if (run_rules) begin
            if (hz.mem_req_M && !hz.mem_ack_M) begin
                stall_all = 1'b1;
                state_d   = MEM_WAIT;
                cnt_d     = '0;
            end else if (hz.redirect_E) begin
                flush_d = 1'b1;
                flush_e = 1'b1;
            end else if (lu) begin
                stall_fd = 1'b1;
                flush_e  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign hz.stall_F = stall_all | stall_fd;
    assign hz.stall_D = stall_all | stall_fd;
    assign hz.stall_E = stall_all;
    assign hz.stall_M = stall_all;
    assign hz.flush_D = flush_d;
    assign hz.flush_E = flush_e;
    assign mem_err    = (state_q == ERROR);

    fwd_unit #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
        .rs_E(hz.rs1_E), .rd_M(hz.rd_M), .rd_W(hz.rd_W),
        .regwe_M(hz.regwe_M), .regwe_W(hz.regwe_W), .sel(fwd_a)
    );
    fwd_unit #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
        .rs_E(hz.rs2_E), .rd_M(hz.rd_M), .rd_W(hz.rd_W),
        .regwe_M(hz.regwe_M), .regwe_W(hz.regwe_W), .sel(fwd_b)
    );
    assign hz.fwd_a_E = fwd_a;
    assign hz.fwd_b_E = fwd_b;

`ifdef PIPE_HAZARD_PERF_EN
    logic [PERF_CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (hz.stall_F && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + PERF_CNT_W'(1);
            if (flush_e && flush_cnt_q != '1)    flush_cnt_q <= flush_cnt_q + PERF_CNT_W'(1);
        end
    end

    assign perf_stall_cnt = stall_cnt_q;
    assign perf_flush_cnt = flush_cnt_q;
`else
    assign perf_stall_cnt = '0;
    assign perf_flush_cnt = '0;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed vectors push expected controls, a negedge monitor checks them.
module tb_pipe_hazard_ctrl;
    import pipe_ctrl_pkg::*;

`ifdef PIPE_HAZARD_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        mem_err;
    logic [31:0] psc, pfc;

    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.REG_ADDR_W(5)) hz();

    pipe_hazard_ctrl #(.REG_ADDR_W(5), .MEM_TIMEOUT(16), .PERF_CNT_W(32)) dut (
        .clk(clk), .rstn(rstn), .hz(hz),
        .mem_err(mem_err), .perf_stall_cnt(psc), .perf_flush_cnt(pfc)
    );

    // exp bits: {stall_F,stall_D,stall_E,stall_M, flush_D,flush_E, fwd_a[1:0], fwd_b[1:0], mem_err}
    typedef struct {
        string      name;
        logic [10:0] exp;
        logic        rst;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [10:0] ex(input logic [3:0] st, input logic [1:0] fl,
                                       input logic [1:0] fa, input logic [1:0] fb,
                                       input logic err);
        return {st, fl, fa, fb, err};
    endfunction

    task automatic idle_inputs();
        rstn = 1'b1;
        hz.rs1_D = '0; hz.rs2_D = '0; hz.rs1_E = '0; hz.rs2_E = '0;
        hz.rd_E = '0; hz.rd_M = '0; hz.rd_W = '0;
        hz.use_rs1_D = 1'b0; hz.use_rs2_D = 1'b0;
        hz.load_E = 1'b0; hz.regwe_M = 1'b0; hz.regwe_W = 1'b0;
        hz.redirect_E = 1'b0; hz.mem_req_M = 1'b0; hz.mem_ack_M = 1'b0;
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic push(input string nm, input logic [10:0] e);
        sb.push_back('{name: nm, exp: e, rst: ~rstn});
    endtask

    initial begin : monitor
        exp_t        t;
        logic [10:0] act;
        logic [31:0] es, ef, want_s, want_f;
        es = '0;
        ef = '0;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                t   = sb.pop_front();
                act = {hz.stall_F, hz.stall_D, hz.stall_E, hz.stall_M,
                       hz.flush_D, hz.flush_E, hz.fwd_a_E, hz.fwd_b_E, mem_err};
                checks++;
                if (act !== t.exp) begin
                    errors++;
                    $display("FAIL %s: got %b required %b (sF sD sE sM fD fE fa fb err)",
                             t.name, act, t.exp);
                end
                want_s = PERF ? es : 32'd0;
                want_f = PERF ? ef : 32'd0;
                checks++;
                if (psc !== want_s || pfc !== want_f) begin
                    errors++;
                    $display("FAIL %s_perf: got stall=%0d flush=%0d required stall=%0d flush=%0d",
                             t.name, psc, pfc, want_s, want_f);
                end
                if (t.rst) begin
                    es = '0;
                    ef = '0;
                end else begin
                    if (t.exp[10] && es != '1) es = es + 32'd1;
                    if (t.exp[5]  && ef != '1) ef = ef + 32'd1;
                end
            end
        end
    end

    initial begin : stimulus
        idle_inputs();
        rstn = 1'b0;
        repeat (2) @(posedge clk);

        next_cyc(); push("reset_idle", ex(4'b0000, 2'b00, 2'b00, 2'b00, 1'b0));

        next_cyc(); hz.load_E = 1; hz.rd_E = 5; hz.rs1_D = 5; hz.use_rs1_D = 1;
        push("lu_rs1", ex(4'b1100, 2'b01, 2'b00, 2'b00, 1'b0));
        next_cyc(); hz.rs1_D = 5; hz.use_rs1_D = 1; hz.rd_M = 5;
        push("lu_released", ex(4'b0000, 2'b00, 2'b00, 2'b00, 1'b0));
        next_cyc(); hz.load_E = 1; hz.rd_E = 0; hz.rs1_D = 0; hz.use_rs1_D = 1;
        push("lu_x0", ex(4'b0000, 2'b00, 2'b00, 2'b00, 1'b0));
        next_cyc(); hz.load_E = 1; hz.rd_E = 5; hz.rs1_D = 5; hz.use_rs1_D = 0;
        push("lu_unused", ex(4'b0000, 2'b00, 2'b00, 2'b00, 1'b0));
        next_cyc(); hz.load_E = 1; hz.rd_E = 9; hz.rs2_D = 9; hz.use_rs2_D = 1;
        push("lu_rs2", ex(4'b1100, 2'b01, 2'b00, 2'b00, 1'b0));
        next_cyc(); hz.load_E = 1; hz.rd_E = 5; hz.rs1_D = 5; hz.use_rs1_D = 1; hz.redirect_E = 1;
        push("redirect_over_lu", ex(4'b0000, 2'b11, 2'b00, 2'b00, 1'b0));

        next_cyc(); hz.mem_req_M = 1; hz.mem_ack_M = 1;
        push("mem_single", ex(4'b0000, 2'b00, 2'b00, 2'b00, 1'b0));
        for (int i = 0; i < 3; i++) begin
            next_cyc(); hz.mem_req_M = 1; hz.redirect_E = (i == 2);
            push("mem_wait", ex(4'b1111, 2'b00, 2'b00, 2'b00, 1'b0));
        end
        next_cyc(); hz.mem_req_M = 1; hz.mem_ack_M = 1; hz.redirect_E = 1;
        push("mem_ack_redirect", ex(4'b0000, 2'b11, 2'b00, 2'b00, 1'b0));
        next_cyc();
        push("mem_back_run", ex(4'b0000, 2'b00, 2'b00, 2'b00, 1'b0));

        next_cyc(); hz.rs1_E = 7; hz.rd_M = 7; hz.regwe_M = 1; hz.rd_W = 7; hz.regwe_W = 1;
        push("fwd_m_prio", ex(4'b0000, 2'b00, 2'b10, 2'b00, 1'b0));
        next_cyc(); hz.rs1_E = 7; hz.rd_M = 7; hz.regwe_M = 0; hz.rd_W = 7; hz.regwe_W = 1;
        push("fwd_w", ex(4'b0000, 2'b00, 2'b01, 2'b00, 1'b0));
        next_cyc(); hz.rs1_E = 0; hz.rs2_E = 0; hz.rd_M = 0; hz.regwe_M = 1; hz.rd_W = 0; hz.regwe_W = 1;
        push("fwd_x0", ex(4'b0000, 2'b00, 2'b00, 2'b00, 1'b0));
        next_cyc(); hz.rs1_E = 4; hz.rs2_E = 3; hz.rd_M = 4; hz.regwe_M = 1; hz.rd_W = 3; hz.regwe_W = 1;
        push("fwd_mix", ex(4'b0000, 2'b00, 2'b10, 2'b01, 1'b0));
        next_cyc(); hz.rs1_E = 6; hz.rs2_E = 6; hz.rd_M = 6; hz.rd_W = 6;
        push("fwd_no_we", ex(4'b0000, 2'b00, 2'b00, 2'b00, 1'b0));

        next_cyc(); hz.mem_req_M = 1;
        push("to_enter", ex(4'b1111, 2'b00, 2'b00, 2'b00, 1'b0));
        for (int i = 0; i < 15; i++) begin
            next_cyc(); hz.mem_req_M = 1; hz.rs1_E = 7; hz.rd_W = 7; hz.regwe_W = 1;
            push("to_wait", ex(4'b1111, 2'b00, 2'b01, 2'b00, 1'b0));
        end
        for (int i = 0; i < 2; i++) begin
            next_cyc(); hz.mem_req_M = 1; hz.mem_ack_M = (i == 1);
            push("to_error", ex(4'b1111, 2'b00, 2'b00, 2'b00, 1'b1));
        end
        next_cyc(); rstn = 0;
        push("to_reset_cycle", ex(4'b1111, 2'b00, 2'b00, 2'b00, 1'b1));
        next_cyc();
        push("to_after_reset", ex(4'b0000, 2'b00, 2'b00, 2'b00, 1'b0));

        for (int i = 0; i < 2; i++) begin
            next_cyc(); hz.mem_req_M = 1;
            push("midwait_stall", ex(4'b1111, 2'b00, 2'b00, 2'b00, 1'b0));
        end
        next_cyc(); rstn = 0; hz.mem_req_M = 1;
        push("midwait_reset", ex(4'b1111, 2'b00, 2'b00, 2'b00, 1'b0));
        next_cyc();
        push("midwait_run", ex(4'b0000, 2'b00, 2'b00, 2'b00, 1'b0));
        next_cyc(); hz.load_E = 1; hz.rd_E = 12; hz.rs2_D = 12; hz.use_rs2_D = 1;
        push("lu_after_reset", ex(4'b1100, 2'b01, 2'b00, 2'b00, 1'b0));

        next_cyc();
        repeat (3) @(posedge clk);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending entries required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
